// File: rtl/wb_grf_if.sv
// Bus bundle between the M->W pipeline register / D-stage read logic and the wb_grf block.
// The slave modport is the register-file side. The master modport is the pipeline side.
interface wb_grf_if #(
    parameter int CNT_W = 32
);
    logic             RegWrite_W;
    logic [1:0]       Wlevel_Sel_W;
    logic [2:0]       Ld_Type_W;
    logic [31:0]      PC_W;
    logic [31:0]      AO_W;
    logic [31:0]      DR_W;
    logic [4:0]       A3_W;
    logic [4:0]       A1_D;
    logic [4:0]       A2_D;
    logic [31:0]      RD1_D;
    logic [31:0]      RD2_D;
    logic [31:0]      WD_W;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  RegWrite_W, Wlevel_Sel_W, Ld_Type_W, PC_W, AO_W, DR_W, A3_W, A1_D, A2_D,
        output RD1_D, RD2_D, WD_W, retired
    );

    modport master (
        output RegWrite_W, Wlevel_Sel_W, Ld_Type_W, PC_W, AO_W, DR_W, A3_W, A1_D, A2_D,
        input  RD1_D, RD2_D, WD_W, retired
    );
endinterface

// File: rtl/wb_grf.sv
// MIPS writeback stage and 32x32 register file with W->D bypass and a retired-instruction counter.
// Optional: define GRF_DISPLAY_EN to print every register write.
module wb_grf #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic     clk,
    input  logic     reset,
    wb_grf_if.slave  bus
);

    logic [31:0]      r_grf [0:31];
    logic [CNT_W-1:0] r_retired;
    logic [31:0]      w_ext;
    logic [31:0]      w_wd;
    logic [31:0]      w_rd1;
    logic [31:0]      w_rd2;
    logic             w_we;
    logic             w_count;

    function automatic logic [31:0] load_ext(input logic [31:0] dr,
                                             input logic [1:0]  off,
                                             input logic [2:0]  ld_type);
        logic [7:0]  b;
        logic [15:0] h;
        b = dr[8*off +: 8];
        h = off[1] ? dr[31:16] : dr[15:0];
        case (ld_type)
            3'd1:    load_ext = {24'h00_0000, b};
            3'd2:    load_ext = {{24{b[7]}}, b};
            3'd3:    load_ext = {16'h0000, h};
            3'd4:    load_ext = {{16{h[15]}}, h};
            default: load_ext = dr;
        endcase
    endfunction

    function automatic logic [31:0] read_port(input logic        rst_ok,
                                              input logic [4:0]  addr,
                                              input logic        we,
                                              input logic [4:0]  waddr,
                                              input logic [31:0] wd,
                                              input logic [31:0] stored);
        if (!rst_ok || addr == 5'd0) begin
            read_port = 32'h0000_0000;
        end else if (we && waddr == addr) begin
            read_port = wd;
        end else begin
            read_port = stored;
        end
    endfunction

    // Writeback source selection and load extension
    always_comb begin
        w_ext = load_ext(bus.DR_W, bus.AO_W[1:0], bus.Ld_Type_W);
        case (bus.Wlevel_Sel_W)
            2'd1:    w_wd = w_ext;
            2'd2:    w_wd = bus.PC_W + 32'd8;
            default: w_wd = bus.AO_W;
        endcase
    end

    // Write enable, counter qualifier and bypassed read ports
    always_comb begin
        w_we    = bus.RegWrite_W && (bus.A3_W != 5'd0);
        w_count = (bus.PC_W != RESET_PC) && (bus.PC_W != 32'h0000_0000);
        w_rd1   = read_port(reset, bus.A1_D, w_we, bus.A3_W, w_wd, r_grf[bus.A1_D]);
        w_rd2   = read_port(reset, bus.A2_D, w_we, bus.A3_W, w_wd, r_grf[bus.A2_D]);
    end

    // Register file storage; $0 is never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_grf[i] <= 32'h0000_0000;
            end
        end else if (w_we) begin
            r_grf[bus.A3_W] <= w_wd;
        end else begin
            r_grf[0] <= 32'h0000_0000;
        end
    end

    // Retired counter skips bubbles (reset PC or the cleared W register)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= {CNT_W{1'b0}};
        end else if (w_count) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_retired <= r_retired;
        end
    end

`ifdef GRF_DISPLAY_EN
    // Write trace, including attempted writes to $0
    always @(posedge clk) begin
        if (reset && bus.RegWrite_W) begin
            $display("%d@%h: $%d <= %h", $time, bus.PC_W, bus.A3_W, w_wd);
        end
    end
`else
`endif

    assign bus.WD_W    = w_wd;
    assign bus.RD1_D   = w_rd1;
    assign bus.RD2_D   = w_rd2;
    assign bus.retired = r_retired;

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: stimulus queues expected values, a negedge monitor compares them.
module tb_wb_grf;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          CNT_W    = 32;

    typedef struct {
        int          sel;   // 0 RD1_D, 1 RD2_D, 2 WD_W, 3 retired
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clk;
    logic reset;
    chk_t q[$];
    int   n_checks;
    int   n_fail;

    wb_grf_if #(.CNT_W(CNT_W)) bus ();

    wb_grf #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [2:0] ld,
                         input logic [31:0] pc, input logic [31:0] ao, input logic [31:0] dr,
                         input logic [4:0] a3, input logic [4:0] a1, input logic [4:0] a2);
        bus.RegWrite_W   = we;
        bus.Wlevel_Sel_W = sel;
        bus.Ld_Type_W    = ld;
        bus.PC_W         = pc;
        bus.AO_W         = ao;
        bus.DR_W         = dr;
        bus.A3_W         = a3;
        bus.A1_D         = a1;
        bus.A2_D         = a2;
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = q.pop_front();
            case (c.sel)
                0:       act = bus.RD1_D;
                1:       act = bus.RD2_D;
                2:       act = bus.WD_W;
                default: act = bus.retired;
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] DR = 32'h80FF_7F01;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #2;
        // Reset pulsed low mid-cycle
        reset = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        expect_val(0, 32'h0, "reset_rd1");
        expect_val(1, 32'h0, "reset_rd2");
        expect_val(3, 32'h0, "reset_retired");
        cyc(); reset = 1'b1;
        expect_val(3, 32'h0, "post_reset_retired_a");
        cyc();
        expect_val(3, 32'h0, "post_reset_retired_b");
        expect_val(0, 32'h0, "post_reset_r5");

        // ALU writeback with same-cycle bypass
        cyc(); drive(1'b1, 2'd0, 3'd0, 32'h0, 32'h1234_5678, 32'h0, 5'd8, 5'd8, 5'd0);
        expect_val(2, 32'h1234_5678, "alu_wd");
        expect_val(0, 32'h1234_5678, "alu_bypass");
        cyc(); drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h1234_5678, 32'h0, 5'd8, 5'd8, 5'd0);
        expect_val(0, 32'h1234_5678, "alu_stored");

        // Load extension
        cyc(); drive(1'b1, 2'd1, 3'd2, 32'h0, 32'h0000_0003, DR, 5'd9, 5'd9, 5'd0);
        expect_val(2, 32'hFFFF_FF80, "lb_off3");
        expect_val(0, 32'hFFFF_FF80, "lb_off3_bypass");
        cyc(); drive(1'b1, 2'd1, 3'd1, 32'h0, 32'h0000_0002, DR, 5'd9, 5'd9, 5'd0);
        expect_val(2, 32'h0000_00FF, "lbu_off2");
        cyc(); drive(1'b1, 2'd1, 3'd4, 32'h0, 32'h0000_0002, DR, 5'd9, 5'd9, 5'd0);
        expect_val(2, 32'hFFFF_80FF, "lh_off2");
        cyc(); drive(1'b1, 2'd1, 3'd3, 32'h0, 32'h0000_0000, DR, 5'd9, 5'd9, 5'd0);
        expect_val(2, 32'h0000_7F01, "lhu_off0");
        cyc(); drive(1'b1, 2'd1, 3'd2, 32'h0, 32'h0000_0001, DR, 5'd9, 5'd9, 5'd0);
        expect_val(2, 32'h0000_007F, "lb_off1");
        cyc(); drive(1'b1, 2'd1, 3'd7, 32'h0, 32'h0000_0002, DR, 5'd9, 5'd9, 5'd0);
        expect_val(2, 32'h80FF_7F01, "ld_other_is_lw");
        cyc(); drive(1'b1, 2'd1, 3'd0, 32'h0, 32'h0000_0000, DR, 5'd9, 5'd9, 5'd0);
        expect_val(2, 32'h80FF_7F01, "lw");
        cyc(); drive(1'b0, 2'd3, 3'd0, 32'h0, 32'h0000_0055, DR, 5'd9, 5'd9, 5'd0);
        expect_val(0, 32'h80FF_7F01, "lw_stored");
        expect_val(2, 32'h0000_0055, "sel3_is_ao");

        // jal link and PC+8 wrap
        cyc(); drive(1'b1, 2'd2, 3'd0, 32'h0000_3010, 32'h0, 32'h0, 5'd31, 5'd0, 5'd31);
        expect_val(2, 32'h0000_3018, "jal_wd");
        expect_val(1, 32'h0000_3018, "jal_bypass_rd2");
        cyc(); drive(1'b0, 2'd2, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd31, 5'd0, 5'd31);
        expect_val(2, 32'h0000_0004, "jal_wrap_wd");
        expect_val(1, 32'h0000_3018, "jal_stored_r31");
        expect_val(3, 32'd1, "retired_after_jal");
        cyc(); drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_val(3, 32'd2, "retired_after_wrap_pc");

        // $0 protection
        cyc(); drive(1'b1, 2'd0, 3'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 5'd8);
        expect_val(0, 32'h0, "r0_before_edge");
        expect_val(2, 32'hDEAD_BEEF, "r0_wd");
        expect_val(1, 32'h1234_5678, "r8_unaffected");
        cyc(); drive(1'b0, 2'd0, 3'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 5'd8);
        expect_val(0, 32'h0, "r0_after_edge");

        // Dual bypass, then back-to-back writes to the same register
        cyc(); drive(1'b1, 2'd0, 3'd0, 32'h0, 32'hCAFE_0001, 32'h0, 5'd12, 5'd12, 5'd12);
        expect_val(0, 32'hCAFE_0001, "dual_bypass_rd1");
        expect_val(1, 32'hCAFE_0001, "dual_bypass_rd2");
        cyc(); drive(1'b1, 2'd0, 3'd0, 32'h0, 32'hCAFE_0002, 32'h0, 5'd12, 5'd12, 5'd12);
        expect_val(0, 32'hCAFE_0002, "b2b_bypass");
        cyc(); drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd12, 5'd12, 5'd12);
        expect_val(1, 32'hCAFE_0002, "b2b_last_wins");

        // Write coinciding with reset is lost
        cyc(); drive(1'b1, 2'd0, 3'd0, 32'h0, 32'h1111_1111, 32'h0, 5'd12, 5'd12, 5'd8);
        reset = 1'b0;
        expect_val(0, 32'h0, "reset_blocks_bypass");
        cyc(); reset = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd12, 5'd12, 5'd8);
        expect_val(0, 32'h0, "write_lost_on_reset");
        expect_val(1, 32'h0, "r8_cleared");
        expect_val(3, 32'h0, "retired_cleared");

        // Counter: 10 real instructions then 2 bubbles
        for (int k = 0; k < 10; k++) begin
            cyc(); drive(1'b0, 2'd0, 3'd0, 32'h0000_3004 + 32'(4 * k), 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(); drive(1'b0, 2'd0, 3'd0, RESET_PC, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
            expect_val(3, 32'd10, "retired_ten");
        end
        cyc(); drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_val(3, 32'd10, "retired_bubble_skip");
        cyc(); reset = 1'b0;
        expect_val(3, 32'h0, "retired_reset");
        cyc(); reset = 1'b1;
        expect_val(3, 32'h0, "retired_after_release");

        cyc();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
